// File: rtl/index_to_onehot_pulser_if.sv
`default_nettype none
// ============================================================================
// Module      : index_to_onehot_pulser_if
// Description : Valid/ready index handshake between the encoder side and the
//               one-hot pulser.
// Revision    : 1.0 - initial release
// ============================================================================
interface index_to_onehot_pulser_if #(
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_idx,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_idx,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/index_to_onehot_pulser.sv
`default_nettype none
// ============================================================================
// Module      : index_to_onehot_pulser
// Description : Queues 4-bit indices in a small FIFO and replays each as a
//               one-hot strobe of PULSE_LEN cycles, separated by GAP_LEN zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module index_to_onehot_pulser #(
    parameter int IDX_W     = 4,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int DEPTH     = 2
) (
    input  wire                       clk,
    input  wire                       rst,
    index_to_onehot_pulser_if.slave   bus,
    output logic [(2**IDX_W)-1:0]     onehot,
    output logic                      done,
    output logic                      busy
);

    localparam int c_OH_W    = 2 ** IDX_W;
    localparam int c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_FCNT_W  = $clog2(DEPTH + 1);
    localparam int c_CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_FCNT_W-1:0] c_DEPTH_CNT  = c_FCNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST   = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0]  c_PULSE_LOAD = c_CNT_W'(PULSE_LEN - 1);
    localparam logic [c_CNT_W-1:0]  c_GAP_LOAD   = (GAP_LEN > 0) ? c_CNT_W'(GAP_LEN - 1) : '0;
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PULSE = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FCNT_W-1:0] r_fcnt;

    logic                w_in_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]  w_rd_ptr_nxt;
    logic [IDX_W-1:0]    w_head;
    logic [c_OH_W-1:0]   w_head_onehot;

    // Ready is held low during reset so nothing can be queued across it.
    assign w_in_ready   = ~rst & (r_fcnt < c_DEPTH_CNT);
    assign bus.in_ready = w_in_ready;
    assign w_push       = bus.in_valid & w_in_ready;
    assign w_empty      = (r_fcnt == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_onehot = c_OH_W'(1) << w_head;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_idx;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + c_FCNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - c_FCNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe sequencer
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_OH_W-1:0]  r_onehot;
    logic               r_done;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_OH_W-1:0]  w_onehot_nxt;
    logic               w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_onehot <= w_onehot_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_onehot_nxt = r_onehot;
        w_done_nxt   = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_onehot_nxt = w_head_onehot;
                    w_cnt_nxt    = c_PULSE_LOAD;
                    w_state_nxt  = c_ST_PULSE;
                end
            end

            c_ST_PULSE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_done_nxt = 1'b1;
                    if (GAP_LEN > 0) begin
                        w_onehot_nxt = '0;
                        w_cnt_nxt    = c_GAP_LOAD;
                        w_state_nxt  = c_ST_GAP;
                    end else if (!w_empty) begin
                        // Zero-gap mode chains straight into the next strobe.
                        w_pop        = 1'b1;
                        w_onehot_nxt = w_head_onehot;
                        w_cnt_nxt    = c_PULSE_LOAD;
                    end else begin
                        w_onehot_nxt = '0;
                        w_state_nxt  = c_ST_IDLE;
                    end
                end
            end

            c_ST_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_onehot_nxt = w_head_onehot;
                    w_cnt_nxt    = c_PULSE_LOAD;
                    w_state_nxt  = c_ST_PULSE;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_onehot_nxt = '0;
                w_cnt_nxt    = '0;
                w_state_nxt  = c_ST_IDLE;
            end
        endcase
    end

    assign onehot = r_onehot;
    assign done   = r_done;
    assign busy   = (r_state != c_ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_index_to_onehot_pulser.sv
`default_nettype none
// ============================================================================
// Module      : tb_index_to_onehot_pulser
// Description : Vector tables, hand sequences and a randomized index stream
//               checked against a queue-based model of the pulser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_index_to_onehot_pulser;

    localparam int c_PULSE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    index_to_onehot_pulser_if #(.IDX_W(4)) bus_a ();
    index_to_onehot_pulser_if #(.IDX_W(4)) bus_b ();

    logic [15:0] oh_a, oh_b;
    logic        done_a, done_b, busy_a, busy_b;

    index_to_onehot_pulser #(.IDX_W(4), .PULSE_LEN(4), .GAP_LEN(1), .DEPTH(2)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_a.slave),
        .onehot (oh_a),
        .done   (done_a),
        .busy   (busy_a)
    );

    index_to_onehot_pulser #(.IDX_W(4), .PULSE_LEN(4), .GAP_LEN(0), .DEPTH(2)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_b.slave),
        .onehot (oh_b),
        .done   (done_b),
        .busy   (busy_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers indices in order (holding each until taken) and compares the
    // per-cycle trace of onehot/done/in_ready against hand-built tables.
    task automatic trace_run(input bit sel_b, input string tag,
                             input logic [3:0] offs[$], input logic [15:0] exp_oh[$],
                             input logic exp_done[$], input logic exp_rdy[$]);
        int  ptr = 0;
        bit  acc;
        for (int c = 0; c < exp_oh.size(); c++) begin
            if (sel_b) begin
                bus_b.in_valid = (ptr < offs.size());
                bus_b.in_idx   = (ptr < offs.size()) ? offs[ptr] : 4'd0;
                acc            = bus_b.in_valid & bus_b.in_ready;
            end else begin
                bus_a.in_valid = (ptr < offs.size());
                bus_a.in_idx   = (ptr < offs.size()) ? offs[ptr] : 4'd0;
                acc            = bus_a.in_valid & bus_a.in_ready;
            end
            tick();
            if (acc) ptr++;
            chk($sformatf("%s_oh_c%0d", tag, c), sel_b ? oh_b : oh_a, exp_oh[c]);
            chk($sformatf("%s_done_c%0d", tag, c), sel_b ? done_b : done_a, exp_done[c]);
            if (exp_rdy.size() > c)
                chk($sformatf("%s_rdy_c%0d", tag, c), sel_b ? bus_b.in_ready : bus_a.in_ready, exp_rdy[c]);
        end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model for the random phase: a queue of accepted indices;
    // each nonzero run of onehot must equal 1<<(oldest index), last exactly
    // PULSE cycles, and be followed by a single-cycle done.
    // ------------------------------------------------------------------
    bit          mon_en = 1'b0;
    logic [3:0]  model_q[$];
    logic [15:0] prev_oh;
    int          run_len;
    int          n_acc;
    int          n_pulses;

    always @(negedge clk) begin
        if (!mon_en) begin
            model_q.delete();
            prev_oh  = '0;
            run_len  = 0;
            n_acc    = 0;
            n_pulses = 0;
        end else begin
            if (bus_a.in_valid && bus_a.in_ready) begin
                model_q.push_back(bus_a.in_idx);
                n_acc++;
            end
            chk("rand_single_bit", ($countones(oh_a) <= 1), 1);
            chk("rand_done", done_a, (prev_oh != 0) && (oh_a == 0));
            if (oh_a != 0) begin
                if (prev_oh == 0) begin
                    n_pulses++;
                    if (model_q.size() == 0) begin
                        chk("rand_unexpected_pulse", oh_a, 0);
                    end else begin
                        chk("rand_pulse_value", oh_a, 16'h1 << model_q.pop_front());
                    end
                    run_len = 1;
                end else begin
                    chk("rand_pulse_stable", oh_a, prev_oh);
                    run_len++;
                end
            end else if (prev_oh != 0) begin
                chk("rand_pulse_len", run_len, c_PULSE);
            end
            prev_oh = oh_a;
        end
    end

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[5];
    logic [3:0]  offs[$];
    logic [15:0] e_oh[$];
    logic        e_dn[$];
    logic        e_rd[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{idx: 4'd5,  exp: 16'h0020};
        vecs[1] = '{idx: 4'd0,  exp: 16'h0001};
        vecs[2] = '{idx: 4'd15, exp: 16'h8000};
        vecs[3] = '{idx: 4'd7,  exp: 16'h0080};
        vecs[4] = '{idx: 4'd10, exp: 16'h0400};

        // Reset with an index offered: nothing accepted, nothing emitted.
        bus_a.in_valid = 1'b1;
        bus_a.in_idx   = 4'd7;
        bus_b.in_valid = 1'b0;
        bus_b.in_idx   = 4'd0;
        rst            = 1'b1;
        tick();
        tick();
        chk("rst_onehot", oh_a, 16'h0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ready", bus_a.in_ready, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        rst            = 1'b0;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_quiet", oh_a, 16'h0);
            chk("post_rst_busy", busy_a, 1'b0);
        end

        // Single-index expansion table.
        for (int v = 0; v < 5; v++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_idx   = vecs[v].idx;
            chk("vec_ready", bus_a.in_ready, 1'b1);
            tick();
            bus_a.in_valid = 1'b0;
            chk("vec_k_onehot", oh_a, 16'h0);
            chk("vec_k_busy", busy_a, 1'b1);
            for (int p = 0; p < 4; p++) begin
                tick();
                chk($sformatf("vec%0d_pulse", v), oh_a, vecs[v].exp);
                chk("vec_pulse_done", done_a, 1'b0);
            end
            tick();
            chk("vec_end_onehot", oh_a, 16'h0);
            chk("vec_end_done", done_a, 1'b1);
            tick();
            chk("vec_after_done", done_a, 1'b0);
            chk("vec_after_busy", busy_a, 1'b0);
        end

        // FIFO fill with a fourth index waiting while full.
        offs = '{4'd0, 4'd15, 4'd15, 4'd1};
        e_oh = '{16'h0,
                 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0,
                 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0, 16'h0};
        e_dn = '{0, 0,0,0,0,1, 0,0,0,0,1, 0,0,0,0,1, 0,0,0,0,1, 0};
        e_rd = '{1, 1, 0,0,0,0, 1, 0,0,0,0, 1,1,1,1,1, 1,1,1,1,1, 1};
        trace_run(1'b0, "full", offs, e_oh, e_dn, e_rd);
        chk("full_idle_busy", busy_a, 1'b0);

        // Zero-gap chaining on the second instance.
        offs = '{4'd3, 4'd4};
        e_oh = '{16'h0,
                 16'h0008, 16'h0008, 16'h0008, 16'h0008,
                 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0, 16'h0};
        e_dn = '{0, 0,0,0,0, 1,0,0,0, 1, 0};
        e_rd = '{1,1,1,1,1,1,1,1,1,1,1};
        trace_run(1'b1, "nogap", offs, e_oh, e_dn, e_rd);
        chk("nogap_idle_busy", busy_b, 1'b0);

        // Reset during the second pulse cycle discards the queued index.
        bus_a.in_valid = 1'b1;
        bus_a.in_idx   = 4'd9;
        tick();
        bus_a.in_idx   = 4'd2;
        tick();
        bus_a.in_valid = 1'b0;
        chk("mid_rst_pulse1", oh_a, 16'h0200);
        tick();
        chk("mid_rst_pulse2", oh_a, 16'h0200);
        rst = 1'b1;
        tick();
        chk("mid_rst_onehot", oh_a, 16'h0);
        chk("mid_rst_done", done_a, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_ready", bus_a.in_ready, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_no_idx2", oh_a, 16'h0);
            chk("mid_rst_idle", busy_a, 1'b0);
        end

        // Randomized stream against the queue model.
        mon_en = 1'b1;
        for (int c = 0; c < 500; c++) begin
            bit acc;
            if (!bus_a.in_valid && ($urandom_range(0, 2) != 0)) begin
                bus_a.in_valid = 1'b1;
                bus_a.in_idx   = 4'($urandom_range(0, 15));
            end
            acc = bus_a.in_valid & bus_a.in_ready;
            tick();
            if (acc) bus_a.in_valid = 1'b0;
        end
        bus_a.in_valid = 1'b0;
        begin
            int guard = 0;
            while (busy_a && guard < 200) begin
                tick();
                guard++;
            end
            chk("rand_drain", busy_a, 1'b0);
        end
        tick();
        tick();
        chk("rand_queue_empty", model_q.size(), 0);
        chk("rand_pulse_count", n_pulses, n_acc);
        mon_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
